// File: rtl/pwm_multi.sv
// N-channel PWM with a shared period counter and boundary-synchronised shadow registers.
// Optional centre-aligned (triangle) counting is built when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_PERIOD = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                atualiza,
  input  logic                wr_duty_en,
  input  logic [3:0]          wr_ch,
  input  logic [CNT_W-1:0]    wr_duty,
  input  logic                wr_period_en,
  input  logic [CNT_W-1:0]    wr_period,
  input  logic                center,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] sinal,
  output logic                period_done
);

  localparam logic [CNT_W-1:0] P_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period_act, period_sh;
  logic [CNT_W-1:0] duty_act [CHANNELS];
  logic [CNT_W-1:0] duty_sh  [CHANNELS];
  logic             pending;
  logic             boundary;
  logic             xfer;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {UP, DOWN} dir_t;

  dir_t dir;
  logic center_act, center_sh;
  logic center_mode;

  // P=0 falls back to edge counting; P=1 reaches its boundary on the way up.
  assign center_mode = center_act && (period_act != '0);
  assign boundary    = center_mode ? (counter == ONE && (dir == DOWN || period_act == ONE))
                                   : (counter == period_act);

  always_ff @(posedge clock) begin
    if (reset) begin
      center_sh  <= 1'b0;
      center_act <= 1'b0;
      dir        <= UP;
    end else begin
      center_sh <= center;
      if (xfer) center_act <= center_sh;
      if (boundary) dir <= UP;
      else if (center_mode && dir == UP && counter == period_act) dir <= DOWN;
    end
  end
`else
  logic unused_center;

  assign unused_center = center;
  assign boundary      = (counter == period_act);
`endif

  assign xfer = boundary && (pending || atualiza);

  // NOTE: every register here is assigned with <= so all updates use pre-edge values;
  // this is what makes a same-cycle shadow write miss the transfer it coincides with.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter     <= '0;
      period_act  <= P_RST;
      period_sh   <= P_RST;
      pending     <= 1'b0;
      sinal       <= '0;
      period_done <= 1'b0;
      // NOTE: the duty arrays are a handful of flops, not RAM, so they take reset like any register.
      for (int i = 0; i < CHANNELS; i++) begin
        duty_act[i] <= '0;
        duty_sh[i]  <= '0;
      end
    end else begin
      if (wr_period_en) period_sh <= wr_period;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_duty_en && wr_ch == 4'(i)) duty_sh[i] <= wr_duty;
        sinal[i] <= enable[i] && (counter < duty_act[i]);
      end

      period_done <= boundary;

      if (xfer) begin
        period_act <= period_sh;
        for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh[i];
        pending <= 1'b0;
      end else if (atualiza) begin
        pending <= 1'b1;
      end

      if (boundary) begin
        counter <= '0;
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
        if (center_mode && (dir == DOWN || counter == period_act)) counter <= counter - ONE;
        else counter <= counter + ONE;
`else
        counter <= counter + ONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: measures period length and per-channel high counts
// between period_done pulses and compares them with hand-computed values.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          atualiza;
  logic          wr_duty_en;
  logic [3:0]    wr_ch;
  logic [W-1:0]  wr_duty;
  logic          wr_period_en;
  logic [W-1:0]  wr_period;
  logic          center;
  logic [CH-1:0] enable;
  logic [CH-1:0] sinal;
  logic          period_done;

  int checks = 0;
  int errors = 0;
  int len;
  int hi [CH];

  pwm_multi #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_PERIOD(100)) dut (
    .clock(clock), .reset(reset), .atualiza(atualiza), .wr_duty_en(wr_duty_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .wr_period_en(wr_period_en), .wr_period(wr_period),
    .center(center), .enable(enable), .sinal(sinal), .period_done(period_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // NOTE: outputs are sampled 1 time unit after the edge, never on it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    atualiza     = 1'b0;
    wr_duty_en   = 1'b0;
    wr_period_en = 1'b0;
  endtask

  // Runs until period_done, optionally driving one single-cycle action at tick act_at.
  task automatic run(input int act_at, input logic a_upd, input logic a_wde,
                     input logic [3:0] a_ch, input logic [W-1:0] a_duty,
                     input logic a_wpe, input logic [W-1:0] a_per);
    len = 0;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    do begin
      if (len == act_at) begin
        atualiza     = a_upd;
        wr_duty_en   = a_wde;
        wr_ch        = a_ch;
        wr_duty      = a_duty;
        wr_period_en = a_wpe;
        wr_period    = a_per;
      end
      tick();
      clear_strobes();
      len++;
      for (int c = 0; c < CH; c++) if (sinal[c]) hi[c]++;
    end while (!period_done && len < 600);
    check("period_done_seen", int'(period_done), 1);
  endtask

  task automatic run_plain();
    run(-1, 1'b0, 1'b0, 4'd0, '0, 1'b0, '0);
  endtask

  task automatic expect_counts(input string tag, input int l,
                               input int h0, input int h1, input int h2, input int h3);
    check({tag, ".len"}, len, l);
    check({tag, ".hi0"}, hi[0], h0);
    check({tag, ".hi1"}, hi[1], h1);
    check({tag, ".hi2"}, hi[2], h2);
    check({tag, ".hi3"}, hi[3], h3);
  endtask

  task automatic expect_period(input string tag, input int l,
                               input int h0, input int h1, input int h2, input int h3);
    run_plain();
    expect_counts(tag, l, h0, h1, h2, h3);
  endtask

  task automatic write_duty(input logic [3:0] ch, input logic [W-1:0] d, input logic upd);
    wr_duty_en = 1'b1;
    wr_ch      = ch;
    wr_duty    = d;
    atualiza   = upd;
    tick();
    clear_strobes();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_strobes();
    wr_ch = '0; wr_duty = '0; wr_period = '0;
    center = 1'b0;
    enable = '1;
    tick();
    tick();
    check("reset.sinal", int'(sinal), 0);
    check("reset.period_done", int'(period_done), 0);
    reset = 1'b0;

    // Default P=100: write duty0=25 with atualiza; first transfer at counter 100.
    run(0, 1'b1, 1'b1, 4'd0, 8'd25, 1'b0, '0);
    expect_counts("t1.first", 101, 0, 0, 0, 0);
    expect_period("t1a", 101, 25, 0, 0, 0);
    expect_period("t1b", 101, 25, 0, 0, 0);

    // duty 0 / 101 / 200 with P=100: constant low and constant high.
    write_duty(4'd1, 8'd0, 1'b0);
    write_duty(4'd2, 8'd101, 1'b0);
    write_duty(4'd3, 8'd200, 1'b1);
    run_plain();
    expect_period("t2a", 101, 25, 0, 101, 101);
    expect_period("t2b", 101, 25, 0, 101, 101);

    // Mid-period P=10 and duty0=5 together with atualiza: old period runs to 100.
    run(40, 1'b1, 1'b1, 4'd0, 8'd5, 1'b1, 8'd10);
    expect_counts("t3.old", 101, 25, 0, 101, 101);
    expect_period("t3b", 11, 5, 0, 11, 11);
    expect_period("t3c", 11, 5, 0, 11, 11);

    // Out-of-range channel write must not alias onto any real channel.
    write_duty(4'd7, 8'd0, 1'b1);
    run_plain();
    expect_period("t4a", 11, 5, 0, 11, 11);

    // Enable drop on channel 0 at counter 1.
    tick();
    check("t4.en_before", int'(sinal[0]), 1);
    enable = 4'b1110;
    tick();
    check("t4.en_off", int'(sinal[0]), 0);
    check("t4.en_other", int'(sinal[3]), 1);
    run_plain();
    expect_period("t4b", 11, 0, 0, 11, 11);
    enable = '1;

    // atualiza on the boundary with a simultaneous duty0=50 write: pre-write shadow (3) moves.
    write_duty(4'd0, 8'd3, 1'b0);
    run_plain();
    run(10, 1'b1, 1'b1, 4'd0, 8'd50, 1'b0, '0);
    expect_counts("t5.old", 11, 5, 0, 11, 11);
    expect_period("t5b", 11, 3, 0, 11, 11);
    expect_period("t5c", 11, 3, 0, 11, 11);
    run(0, 1'b1, 1'b0, 4'd0, '0, 1'b0, '0);
    expect_period("t5d", 11, 11, 0, 11, 11);

    // Reset mid-period discards a pending P=20 transfer and restores defaults.
    wr_period_en = 1'b1;
    wr_period    = 8'd20;
    atualiza     = 1'b1;
    tick();
    clear_strobes();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t6.sinal", int'(sinal), 0);
    check("t6.period_done", int'(period_done), 0);
    reset = 1'b0;
    run_plain();
    expect_counts("t6.first", 101, 0, 0, 0, 0);
    expect_period("t6b", 101, 0, 0, 0, 0);

`ifdef PWM_CENTER_ALIGN_EN
    // Triangle counting: P=10, duty0=4 gives 20-cycle periods with 7 high cycles.
    center = 1'b1;
    run(0, 1'b1, 1'b1, 4'd0, 8'd4, 1'b1, 8'd10);
    expect_period("tc.a", 20, 7, 0, 0, 0);
    expect_period("tc.b", 20, 7, 0, 0, 0);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    check("tc.reset_sinal", int'(sinal), 0);
    reset  = 1'b0;
    center = 1'b0;
    run_plain();
    check("tc.reset_len", len, 101);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
